// File: rtl/threshold_trigger_multi.sv
// Hysteresis-qualified PCM trigger: prime on one threshold, fire on the other,
// with N-sample qualification, optional auto-rearm/holdoff and a saturating trigger counter.
module threshold_trigger_multi #(
  parameter int WIDTH      = 16,
  parameter int THRESH_HI  = 600,
  parameter int THRESH_LO  = 500,
  parameter int QUALIFY    = 1,
  parameter int AUTO_REARM = 0,
  parameter int HOLDOFF    = 0
) (
  input  logic                    pcm_clk,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    clear,
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] pcm,
  input  logic                    pcm_valid,
  output logic                    armed,
  output logic                    triggered,
  output logic                    trig_pulse,
  output logic [7:0]              trig_count
);

  localparam logic signed [WIDTH-1:0] HI_S  = WIDTH'(THRESH_HI);
  localparam logic signed [WIDTH-1:0] LO_S  = WIDTH'(THRESH_LO);
  localparam logic signed [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [7:0]              QUAL_N = 8'(QUALIFY);
  localparam logic [15:0]             HOLD_N = 16'(HOLDOFF);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_QUAL, S_FIRED, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [7:0]                qual_q, qual_d;
  logic [15:0]               hold_q, hold_d;
  logic [7:0]                count_q, count_d;
  logic                      armed_q, armed_d;
  logic                      triggered_q, triggered_d;
  logic                      pulse_q, pulse_d;
  logic signed [WIDTH-1:0]   abs_v;
  logic                      prime, fire;

  // The most negative sample has no positive counterpart, so it clamps to full scale.
  function automatic logic signed [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
    if (x == MIN_S)
      return MAX_S;
    else if (x < 0)
      return -x;
    else
      return x;
  endfunction

  always_comb begin
    abs_v = sat_abs(pcm);
    prime = 1'b0;
    fire  = 1'b0;
    case (mode_q)
      2'b00: begin prime = (pcm < LO_S);   fire = (pcm > HI_S);   end
      2'b01: begin prime = (pcm > HI_S);   fire = (pcm < LO_S);   end
      2'b10: begin prime = 1'b1;           fire = (pcm > HI_S);   end
      default: begin prime = (abs_v < LO_S); fire = (abs_v > HI_S); end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    qual_d      = qual_q;
    hold_d      = hold_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    pulse_d     = 1'b0;
    if (clear) begin
      state_d     = S_IDLE;
      qual_d      = 8'd0;
      hold_d      = 16'd0;
      count_d     = 8'd0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            mode_d  = mode;
            state_d = S_PRIME;
          end
        end
        S_PRIME: begin
          // Level mode is always primed; the priming sample never also counts toward firing.
          if (mode_q == 2'b10 || (pcm_valid && prime)) begin
            state_d = S_QUAL;
            qual_d  = 8'd0;
          end
        end
        S_QUAL: begin
          if (pcm_valid) begin
            if (fire) begin
              if (qual_q + 8'd1 == QUAL_N) begin
                state_d     = S_FIRED;
                qual_d      = 8'd0;
                triggered_d = 1'b1;
                pulse_d     = 1'b1;
                if (count_q != 8'hFF)
                  count_d = count_q + 8'd1;
              end else begin
                qual_d = qual_q + 8'd1;
              end
            end else begin
              qual_d = 8'd0;
            end
          end
        end
        S_FIRED: begin
          if (AUTO_REARM != 0) begin
            hold_d = 16'd0;
            if (HOLD_N == 16'd0) begin
              state_d     = S_PRIME;
              triggered_d = 1'b0;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (pcm_valid) begin
            if (hold_q + 16'd1 == HOLD_N) begin
              state_d     = S_PRIME;
              hold_d      = 16'd0;
              triggered_d = 1'b0;
            end else begin
              hold_d = hold_q + 16'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    armed_d = (state_d == S_PRIME) || (state_d == S_QUAL) || (state_d == S_HOLD);
  end

  always_ff @(posedge pcm_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'b00;
      qual_q      <= 8'd0;
      hold_q      <= 16'd0;
      count_q     <= 8'd0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      qual_q      <= qual_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      pulse_q     <= pulse_d;
    end
  end

  assign armed      = armed_q;
  assign triggered  = triggered_q;
  assign trig_pulse = pulse_q;
  assign trig_count = count_q;

endmodule

// File: tb/tb_threshold_trigger_multi.sv
// Scoreboard bench for threshold_trigger_multi: four configurations share stimulus,
// each armed separately; expected trigger pulses are queued and matched by a monitor.
module tb_threshold_trigger_multi;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [3:0]         arm_v = 4'b0;
  logic               clear = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic signed [15:0] pcm = 16'sd0;
  logic               vld = 1'b0;
  logic [3:0]         armed, triggered, trig_pulse;
  logic [7:0]         trig_count [4];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {int dut; int cyc; int cnt;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  threshold_trigger_multi u0 (
    .pcm_clk(clk), .reset_n(reset_n), .arm(arm_v[0]), .clear(clear), .mode(mode),
    .pcm(pcm), .pcm_valid(vld), .armed(armed[0]), .triggered(triggered[0]),
    .trig_pulse(trig_pulse[0]), .trig_count(trig_count[0]));

  threshold_trigger_multi #(.QUALIFY(3)) u1 (
    .pcm_clk(clk), .reset_n(reset_n), .arm(arm_v[1]), .clear(clear), .mode(mode),
    .pcm(pcm), .pcm_valid(vld), .armed(armed[1]), .triggered(triggered[1]),
    .trig_pulse(trig_pulse[1]), .trig_count(trig_count[1]));

  threshold_trigger_multi #(.THRESH_HI(32766), .THRESH_LO(100)) u2 (
    .pcm_clk(clk), .reset_n(reset_n), .arm(arm_v[2]), .clear(clear), .mode(mode),
    .pcm(pcm), .pcm_valid(vld), .armed(armed[2]), .triggered(triggered[2]),
    .trig_pulse(trig_pulse[2]), .trig_count(trig_count[2]));

  threshold_trigger_multi #(.AUTO_REARM(1), .HOLDOFF(4)) u3 (
    .pcm_clk(clk), .reset_n(reset_n), .arm(arm_v[3]), .clear(clear), .mode(mode),
    .pcm(pcm), .pcm_valid(vld), .armed(armed[3]), .triggered(triggered[3]),
    .trig_pulse(trig_pulse[3]), .trig_count(trig_count[3]));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic do_arm(input int d, input logic [1:0] m);
    arm_v[d] = 1'b1;
    mode = m;
    tick();
    arm_v = 4'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic smp(input int v);
    pcm = 16'(v);
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  // The pulse must appear in the cycle right after the edge that takes the next sample.
  task automatic exp_trig(input int d, input int cnt);
    sb.push_back('{d, cyc + 1, cnt});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (trig_pulse[i]) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse_dut", i, -1);
          end else begin
            e = sb.pop_front();
            chk("pulse_dut", i, e.dut);
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_count", int'(trig_count[i]), e.cnt);
          end
        end
      end
    end
  end

  initial begin
    int seq [6] = '{700, 700, 550, 700, 700, 700};
    gap(3);
    chk("reset_flags", {armed, triggered, trig_pulse}, 0);
    for (int i = 0; i < 4; i++) chk("reset_count", int'(trig_count[i]), 0);
    #2 reset_n = 1'b1;
    gap(2);

    // Rising, defaults
    do_arm(0, 2'b00);
    chk("rise_armed", armed[0], 1);
    smp(700); smp(700);
    chk("rise_not_primed", triggered[0], 0);
    smp(400);
    exp_trig(0, 1); smp(700);
    gap(2);
    chk("rise_triggered", triggered[0], 1);
    chk("rise_count", int'(trig_count[0]), 1);
    chk("rise_pulse_cleared", trig_pulse[0], 0);
    do_arm(0, 2'b00);
    gap(1);
    chk("fired_ignores_arm_trig", triggered[0], 1);
    chk("fired_ignores_arm_armed", armed[0], 0);
    do_clear();

    // Qualify 3, contiguous then with invalid gaps
    for (int g = 0; g < 2; g++) begin
      do_arm(1, 2'b00);
      smp(400);
      for (int i = 0; i < 6; i++) begin
        if (i == 5) begin
          chk("qual_before_6th", triggered[1], 0);
          exp_trig(1, 1);
        end
        smp(seq[i]);
        gap(g * 2);
      end
      gap(1);
      chk("qual_triggered", triggered[1], 1);
      chk("qual_count", int'(trig_count[1]), 1);
      do_clear();
    end

    // Level mode, then clear and rearm
    do_arm(0, 2'b10);
    gap(1);
    smp(600);
    gap(1);
    chk("level_eq_no_fire", triggered[0], 0);
    exp_trig(0, 1); smp(601);
    gap(1);
    chk("level_triggered", triggered[0], 1);
    do_clear();
    chk("clear_triggered", triggered[0], 0);
    chk("clear_count", int'(trig_count[0]), 0);
    chk("clear_armed", armed[0], 0);
    do_arm(0, 2'b00);
    chk("rearm_after_clear", armed[0], 1);
    do_clear();

    // Falling mode
    do_arm(0, 2'b01);
    smp(700);
    exp_trig(0, 1); smp(499);
    gap(1);
    chk("fall_triggered", triggered[0], 1);
    do_clear();
    do_arm(0, 2'b01);
    smp(700); smp(500);
    gap(1);
    chk("fall_eq_no_fire", triggered[0], 0);
    chk("fall_still_armed", armed[0], 1);
    do_clear();

    // Abs mode with saturation
    do_arm(2, 2'b11);
    smp(50);
    exp_trig(2, 1); smp(-32768);
    gap(1);
    chk("abs_triggered", triggered[2], 1);
    chk("abs_count", int'(trig_count[2]), 1);
    do_clear();
    do_arm(2, 2'b11);
    smp(50); smp(32766); smp(-32766);
    gap(1);
    chk("abs_eq_no_fire", triggered[2], 0);
    do_clear();

    // Auto rearm with holdoff 4
    do_arm(3, 2'b00);
    smp(400);
    exp_trig(3, 1); smp(700);
    gap(1);
    chk("hold_triggered", triggered[3], 1);
    chk("hold_armed", armed[3], 1);
    smp(400); smp(700); smp(400);
    chk("hold_still_triggered", triggered[3], 1);
    smp(700);
    chk("hold_dropped", triggered[3], 0);
    smp(400);
    exp_trig(3, 2); smp(700);
    gap(1);
    chk("hold_count2", int'(trig_count[3]), 2);

    // Drive the counter into saturation
    for (int k = 3; k <= 257; k++) begin
      repeat (4) smp(0);
      smp(400);
      exp_trig(3, (k > 255) ? 255 : k);
      smp(700);
      gap(1);
    end
    chk("sat_count", int'(trig_count[3]), 255);
    chk("sat_triggered", triggered[3], 1);

    // Asynchronous reset mid-QUAL and mid-HOLD
    do_arm(1, 2'b00);
    smp(400); smp(700);
    chk("midqual_armed", armed[1], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_flags", {armed, triggered, trig_pulse}, 0);
    chk("async_rst_count1", int'(trig_count[1]), 0);
    chk("async_rst_count3", int'(trig_count[3]), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // arm and clear together
    arm_v[0] = 1'b1;
    clear = 1'b1;
    tick();
    arm_v = 4'b0;
    clear = 1'b0;
    chk("arm_clear_armed", armed[0], 0);
    smp(400); smp(700);
    gap(1);
    chk("arm_clear_idle", armed[0], 0);
    chk("arm_clear_no_trig", triggered[0], 0);

    gap(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_trigger_multi.md
Name: threshold_trigger_multi

Overview:
Parametrised successor to the single-threshold PCM trigger. It adds:
- configurable sample width;
- hysteresis through separate high and low thresholds;
- four trigger modes: rising, falling, level and absolute;
- N-consecutive-sample qualification;
- arm/clear control, optional auto-rearm with holdoff, and a saturating trigger counter.

It sits between the PCM source and the capture/record logic in the audio path and qualifies events on the pcm_clk domain.

Parameters:
WIDTH, 16, PCM sample width (signed two's complement), >=4
THRESH_HI, 600, signed upper threshold; fire level for rising/level/abs modes
THRESH_LO, 500, signed lower threshold; must be <= THRESH_HI; prime level for rising/abs, fire level for falling
QUALIFY, 1, consecutive valid firing samples required to trigger; >=1, <=255
AUTO_REARM, 0, 1 = after a trigger, wait HOLDOFF samples then re-prime automatically
HOLDOFF, 0, valid samples ignored after a trigger when AUTO_REARM=1; 0..65535

Ports:
pcm_clk  in  1  sample clock; all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
arm  in  1  level/pulse; arms trigger from IDLE
clear  in  1  synchronous; returns to IDLE, drops triggered, zeroes trig_count
mode  in  2  00 rising, 01 falling, 10 level, 11 abs; latched when arm is accepted
pcm  in  WIDTH  signed sample
pcm_valid  in  1  sample strobe; pcm is ignored when low
armed  out  1  high in PRIME, QUAL and HOLD states
triggered  out  1  latched trigger flag
trig_pulse  out  1  one-cycle strobe per trigger event
trig_count  out  8  triggers since reset/clear, saturates at 255

Behaviour:
- Clock and reset: one clock (pcm_clk); reset (reset_n) is asynchronous and active-low.
- Reset state: state=IDLE; armed, triggered and trig_pulse=0; trig_count=0; qualify count=0; holdoff count=0; mode_q=00.
- All outputs are registered.

Conditions, evaluated with signed compares at WIDTH bits:
- Mode 00 rising: prime = pcm<THRESH_LO; fire = pcm>THRESH_HI.
- Mode 01 falling: prime = pcm>THRESH_HI; fire = pcm<THRESH_LO.
- Mode 10 level: prime = always true; fire = pcm>THRESH_HI. This is the legacy behaviour.
- Mode 11 abs: a=|pcm|, saturating, so -2^(WIDTH-1) maps to 2^(WIDTH-1)-1. prime = a<THRESH_LO; fire = a>THRESH_HI.
- Strict inequalities throughout: pcm equal to a threshold neither primes nor fires.

States (transitions act only on cycles with pcm_valid=1 unless noted):
- IDLE: when arm=1 (no pcm_valid needed), latch mode into mode_q, then go to PRIME.
- PRIME: on a prime sample, go to QUAL with count=0. In mode 10, go to QUAL on the next cycle unconditionally.
- QUAL:
  - A fire sample increments count. When count reaches QUALIFY, go to FIRED.
  - A non-fire sample resets count to 0 and stays in QUAL. Priming is held, which gives the hysteresis.
  - The same sample may not both prime and fire. Priming completes on one sample; qualifying begins with the next valid sample.
- FIRED entry:
  - triggered=1 and trig_pulse=1 on the cycle after the qualifying sample's edge (latency 1 clock).
  - trig_count increments, saturating at 255.
  - trig_pulse clears on the following cycle.
- FIRED, AUTO_REARM=0: hold until clear. triggered stays 1. arm is ignored.
- FIRED, AUTO_REARM=1: go to HOLD on the next cycle. triggered stays 1.
- HOLD: count HOLDOFF valid samples; these samples are ignored. Then go to PRIME and drop triggered. With HOLDOFF=0, go to PRIME on the cycle after FIRED.

Priority and boundary rules:
- clear beats everything except reset. clear and arm in the same cycle gives IDLE; arm is not accepted.
- arm outside IDLE is ignored. A mode change outside IDLE has no effect until the next arm.
- pcm_valid=0 freezes the qualify and holdoff counters; counting never advances on invalid cycles.
- Reset asserted mid-QUAL or mid-HOLD returns to IDLE immediately. A pending trig_pulse is dropped.
- With trig_count at 255, a further trigger still pulses; the count stays at 255.

Test Plan:
1. Rising mode, defaults, arm. pcm 700, 700 → no trigger (not primed). Then pcm 400 → armed. Then pcm 700 → triggered=1 and one trig_pulse one clock after the 700 edge; trig_count=1.
2. Rising mode, QUALIFY=3, primed with 400. Sequence 700, 700, 550, 700, 700, 700 → trigger only after the 6th sample. Repeat with pcm_valid=0 gaps between samples → same result.
3. Level mode, defaults. pcm 600 → no trigger. Then 601 → trigger. Then clear → triggered=0, trig_count=0, state IDLE; arm again works.
4. Abs mode, THRESH_HI=32766, THRESH_LO=100. pcm 50, then -32768 → trigger (|pcm| saturates to 32767). Falling mode: 700 then 499 → trigger; 500 alone → no trigger.
5. AUTO_REARM=1, HOLDOFF=4, rising mode. Trigger, then 5 valid samples 400, 700, 400, 700, 400 → first 4 ignored, triggered drops, re-primed by the 5th. Then 700 → second trigger; trig_count=2.
6. Assert reset_n low asynchronously mid-QUAL (between clock edges) → all outputs 0 immediately. Separately, assert arm and clear in the same cycle → remains IDLE with armed=0.
